sequence_generator: RTL and testbench
=====================================

# sequence_generator

Serial pattern transmitter that drives a bit stream into the sequence-detector datapath. A start request latches a pattern, its length and a repeat count. The block then shifts the pattern out MSB-first, one bit per clock, with a one-cycle idle gap between repetitions. It produces the stimulus side of the detection protocol for on-chip loopback and self-test.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits; must be ≥2.
- `CNT_W`, default 4: width of the repeat-count field.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `pattern`  input  WIDTH  bits to send; bit `len-1` is sent first.
- `len`  input  $clog2(WIDTH)+1  number of pattern bits.
- `count`  input  CNT_W  number of repetitions.
- `o`  output  1  serial data bit, registered.
- `valid`  output  1  high when `o` carries a pattern or parity bit.
- `busy`  output  1  high from accepted start until completion.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, SEND, PAR (present only with parity), GAP, FIN.
- Reset (asynchronous, `rst`=0):
  - state goes to IDLE.
  - `o`, `valid`, `busy`, `done` = 0.
  - Shift register, bit counter and repeat counter are cleared.
- IDLE:
  - If `start`=1, latch `pattern`, `len` and `count`.
  - `len`=0: go to FIN; no bits are sent.
  - `len`>WIDTH: clamp to WIDTH.
  - `count`=0: treat as 1.
  - Otherwise go to SEND.
- SEND:
  - Drive `o`=`pattern[bit_idx]` and `valid`=1.
  - `bit_idx` counts down from `len-1` to 0.
  - After bit 0, go to PAR if enabled, else GAP if repetitions remain, else FIN.
- PAR: one cycle, `o`=even-parity bit, `valid`=1. Then GAP or FIN.
- GAP: one cycle, `o`=0, `valid`=0. Reload `bit_idx`=`len-1` and decrement the repeat counter. Then SEND.
- FIN: one cycle, `done`=1, `busy`=0, `o`=0, `valid`=0. Then IDLE.
- `start` outside IDLE is ignored. Latched values are not affected by input changes during a transfer.
- `o` is 0 whenever `valid`=0.

## Timing
- Let E be the rising edge on which `start`=1 is sampled in IDLE.
- After E: `busy`=1, and the first bit is on `o` with `valid`=1. Latency from the start edge to the first bit is zero cycles.
- Cycles from E to the edge raising `done`:
  - without parity: N·L + (N−1)
  - with parity: N·(L+1) + (N−1)
  - where L = effective length and N = effective count.
- `done` is high for exactly one cycle.
- `busy` falls on the same edge that `done` rises.
- A new `start` is accepted on the edge that ends the FIN cycle, at the earliest. Back-to-back transfers are therefore separated by one FIN cycle.
- `len`=0: `busy`=1 for zero cycles. `done` pulses in the cycle after E, and no `valid` is asserted.
- Reset asserted mid-transfer: outputs clear immediately, with no `done` pulse. After `rst` is released, the block waits in IDLE for a new `start`.
- Simultaneous `start` and reset release: `start` is ignored unless it is sampled at a clock edge where `rst`=1.

## Configuration
- `SEQGEN_PARITY_EN`:
  - Defined: the PAR state exists. After each repetition, one extra bit is sent with `valid`=1, equal to the XOR of the L transmitted bits.
  - Undefined: no PAR state and no parity hardware. Repetitions are separated by GAP only.

## Test plan
- Without macro: WIDTH=8, `pattern`=8'b1010_0110, `len`=8, `count`=1, pulse `start`.
  - `o` = 1,0,1,0,0,1,1,0 with `valid`=1 for 8 cycles.
  - `done` pulses on cycle 9; `busy` is high for 8 cycles.
- `pattern`=3'b101, `len`=3, `count`=2.
  - `o`/`valid` = 1,0,1 / gap (0, valid 0) / 1,0,1.
  - `done` pulses after 7 cycles.
- Degenerate inputs: `len`=0 → no `valid`, `done` one cycle after start. `count`=0 with `len`=2 → a single repetition. `len`=12 with WIDTH=8 → 8 bits sent.
- `start` held high during a transfer plus a second pulse mid-transfer → neither is accepted. A new transfer begins only after FIN.
- `rst` driven low at bit 4 of an 8-bit transfer → `o`, `valid` and `busy` go to 0 asynchronously with no `done`. A subsequent `start` transmits the full pattern from the MSB.
- With `SEQGEN_PARITY_EN`: `pattern`=4'b1101, `len`=4, `count`=1 → `o` = 1,1,0,1 then parity 1 with `valid`=1. `done` pulses on cycle 6.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with a one-cycle gap between repetitions.
// Optional per-repetition even-parity bit is enabled by defining SEQGEN_PARITY_EN.
module sequence_generator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        pattern,
  input  logic [$clog2(WIDTH):0]  len,
  input  logic [CNT_W-1:0]        count,
  output logic                    o,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned LEN_W = $clog2(WIDTH) + 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
`ifdef SEQGEN_PARITY_EN
    S_PAR,
`endif
    S_GAP,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [LEN_W-1:0]   eff_len_c;
  logic               o_q, o_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQGEN_PARITY_EN
  logic               par_q, par_d;
`endif

  // State and registered outputs; outputs are precomputed from the next state so the first bit lands on the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQGEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign eff_len_c = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  // Next-state logic; FIN also accepts a start so back-to-back transfers are one FIN cycle apart.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
`ifdef SEQGEN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          pat_d   = pattern;
          len_d   = eff_len_c;
          idx_d   = IDX_W'(eff_len_c - LEN_W'(1));
          rep_d   = (count == '0) ? CNT_W'(1) : count;
`ifdef SEQGEN_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = (eff_len_c == '0) ? S_FIN : S_SEND;
        end
      end
      S_SEND: begin
`ifdef SEQGEN_PARITY_EN
        par_d = par_q ^ pat_q[idx_q];
`endif
        if (idx_q == '0) begin
`ifdef SEQGEN_PARITY_EN
          state_d = S_PAR;
`else
          state_d = (rep_q > CNT_W'(1)) ? S_GAP : S_FIN;
`endif
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
`ifdef SEQGEN_PARITY_EN
      S_PAR: state_d = (rep_q > CNT_W'(1)) ? S_GAP : S_FIN;
`endif
      S_GAP: begin
        idx_d   = IDX_W'(len_q - LEN_W'(1));
        rep_d   = rep_q - CNT_W'(1);
`ifdef SEQGEN_PARITY_EN
        par_d   = 1'b0;
`endif
        state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the cycle the next state will occupy.
  always_comb begin
    o_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_SEND: begin
        o_d     = pat_d[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef SEQGEN_PARITY_EN
      S_PAR: begin
        o_d     = par_d;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_GAP:   busy_d = 1'b1;
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: directed, degenerate, back-to-back, reset and randomized transfers
// against a per-cycle expected-output list built from the transfer rules.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] count;
  logic       o, valid, busy, done;

  int errors = 0;
  int checks = 0;

  // Expected {o, valid, busy, done} for each cycle following the start edge.
  logic [3:0] exp_q[$];

  sequence_generator #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst_n), .start(start), .pattern(pattern), .len(len),
    .count(count), .o(o), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_push(input logic [7:0] pat, input int ln, input int cnt);
    int l_eff, n_eff;
    logic p;
    l_eff = (ln > 8) ? 8 : ln;
    n_eff = (cnt == 0) ? 1 : cnt;
    if (l_eff == 0) begin
      exp_q.push_back(4'b0001);
      return;
    end
    for (int r = 0; r < n_eff; r++) begin
      p = 1'b0;
      for (int b = l_eff - 1; b >= 0; b--) begin
        exp_q.push_back({pat[b], 3'b110});
        p = p ^ pat[b];
      end
`ifdef SEQGEN_PARITY_EN
      exp_q.push_back({p, 3'b110});
`endif
      if (r < n_eff - 1) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0; start = 1'b1; pattern = 8'hFF; len = 4'd3; count = 4'd1;
    #1;
    got = {o, valid, busy, done};
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL reset_async: got {o,v,b,d}=%b expected 0000", got);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {o, valid, busy, done};
      checks++;
      if (got !== 4'b0000) begin
        errors++; $display("FAIL reset_hold cycle %0d: got %b expected 0000", i, got);
      end
    end
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {o, valid, busy, done};
      checks++;
      if (got !== 4'b0000) begin
        errors++; $display("FAIL reset_release_idle cycle %0d: got %b expected 0000", i, got);
      end
    end
  endtask

  // Single transfer; inputs are scrambled after the start edge to prove they were latched.
  task automatic test_xfer(input string name, input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] cnt);
    logic [3:0] got, exp;
    int n;
    exp_q.delete();
    model_push(pat, int'(ln), int'(cnt));
    n = exp_q.size();
    pattern = pat; len = ln; count = cnt; start = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; pattern = 8'($urandom); len = 4'($urandom); count = 4'($urandom);
      end
      exp = (i < n) ? exp_q[i] : 4'b0000;
      got = {o, valid, busy, done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s cycle %0d: got {o,v,b,d}=%b expected %b", name, i, got, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [3:0] got, exp;
    int n;
    exp_q.delete();
    model_push(8'hC3, 8, 1);
    n = exp_q.size();
    pattern = 8'hC3; len = 4'd8; count = 4'd1; start = 1'b1;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (i < 3) begin pattern = 8'($urandom); len = 4'd2; count = 4'd3; end
      if (i == 3) start = 1'b0;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      exp = (i < n) ? exp_q[i] : 4'b0000;
      got = {o, valid, busy, done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ignore_start cycle %0d: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    int n, fin_a;
    exp_q.delete();
    model_push(8'h5A, 5, 2);
    fin_a = exp_q.size() - 1;
    model_push(8'hE1, 4, 1);
    n = exp_q.size();
    pattern = 8'h5A; len = 4'd5; count = 4'd2; start = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      exp = (i < n) ? exp_q[i] : 4'b0000;
      got = {o, valid, busy, done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %b expected %b", i, got, exp);
      end
      if (i == 0) begin start = 1'b0; pattern = 8'h00; len = 4'd0; end
      if (i == fin_a) begin start = 1'b1; pattern = 8'hE1; len = 4'd4; count = 4'd1; end
      if (i == fin_a + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp;
    exp_q.delete();
    model_push(8'hB7, 8, 1);
    pattern = 8'hB7; len = 4'd8; count = 4'd1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      exp = exp_q[i];
      got = {o, valid, busy, done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = {o, valid, busy, done};
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_async: got %b expected 0000", got);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {o, valid, busy, done};
      checks++;
      if (got !== 4'b0000) begin
        errors++; $display("FAIL reset_mid_hold cycle %0d: got %b expected 0000", i, got);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {o, valid, busy, done};
      checks++;
      if (got !== 4'b0000) begin
        errors++; $display("FAIL reset_mid_idle cycle %0d: got %b expected 0000", i, got);
      end
    end
    test_xfer("reset_mid_restart", 8'hB7, 4'd8, 4'd1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      test_xfer($sformatf("random_%0d", t), 8'($urandom), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    start = 1'b0; pattern = '0; len = '0; count = '0; rst_n = 1'b0;
    test_reset();
    test_xfer("pattern_a6_len8", 8'b1010_0110, 4'd8, 4'd1);
    test_xfer("pattern_101_x2", 8'b0000_0101, 4'd3, 4'd2);
    test_xfer("len_zero", 8'hFF, 4'd0, 4'd3);
    test_xfer("count_zero", 8'b0000_0010, 4'd2, 4'd0);
    test_xfer("len_clamp", 8'h96, 4'd12, 4'd1);
    test_xfer("len_one_x3", 8'h01, 4'd1, 4'd3);
`ifdef SEQGEN_PARITY_EN
    test_xfer("parity_1101", 8'b0000_1101, 4'd4, 4'd1);
    test_xfer("parity_x2", 8'h3C, 4'd6, 4'd2);
`endif
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
